// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/writeback stage.
package div_pkg;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 64;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation: magnitude of a signed operand or sign restore of a quotient.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         neg,
    input  logic [W-1:0] val,
    output logic [W-1:0] res
);

    // The most negative value maps to itself, which is the correct unsigned magnitude.
    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/div_issue_unit.sv
// Divide issue/writeback stage: sign handling, special cases, core start/wait with timeout,
// and a held result under a valid/ready handshake.
module div_issue_unit
    import div_pkg::*;
#(
    parameter int WIDTH   = div_pkg::WIDTH,
    parameter int TAG_W   = div_pkg::TAG_W,
    parameter int TIMEOUT = div_pkg::TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic             div_exception,
    input  logic             div_finish,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_quotient,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_exception,
    output logic             busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic [WIDTH-1:0] mag_a, mag_b, q_fixed;
    logic             accept, ovf;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid & req_ready;
    assign ovf       = req_signed && (req_dividend == MIN_V) && (req_divisor == ONES);

    div_sign_fix #(.W(WIDTH)) u_fix_a (
        .neg (req_signed & req_dividend[WIDTH-1]),
        .val (req_dividend),
        .res (mag_a)
    );

    div_sign_fix #(.W(WIDTH)) u_fix_b (
        .neg (req_signed & req_divisor[WIDTH-1]),
        .val (req_divisor),
        .res (mag_b)
    );

    div_sign_fix #(.W(WIDTH)) u_fix_q (
        .neg (neg_q),
        .val (div_quotient),
        .res (q_fixed)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            neg_q        <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            wb_valid     <= 1'b0;
            wb_quotient  <= '0;
            wb_tag       <= '0;
            wb_exception <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    wb_tag       <= req_tag;
                    neg_q        <= req_signed & (req_dividend[WIDTH-1] ^ req_divisor[WIDTH-1]);
                    div_dividend <= mag_a;
                    div_divisor  <= mag_b;
                    if (req_divisor == '0) begin
                        wb_quotient  <= '0;
                        wb_exception <= 1'b1;
                        wb_valid     <= 1'b1;
                        state        <= RESP;
                    end else if (ovf) begin
                        wb_quotient  <= MIN_V;
                        wb_exception <= 1'b1;
                        wb_valid     <= 1'b1;
                        state        <= RESP;
                    end else begin
                        div_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    div_start <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // Finish takes priority over a coincident timeout.
                    if (div_finish) begin
                        wb_quotient  <= q_fixed;
                        wb_exception <= div_exception;
                        wb_valid     <= 1'b1;
                        state        <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        wb_quotient  <= '0;
                        wb_exception <= 1'b1;
                        wb_valid     <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: if (wb_ready) begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_unit.sv
// Directed bench for div_issue_unit: normal, signed, special cases, timeout/backpressure, async reset.
module tb_div_issue_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_signed;
    logic        req_ready;
    logic [31:0] req_dividend, req_divisor;
    logic [4:0]  req_tag;
    logic        div_start;
    logic [31:0] div_dividend, div_divisor, div_quotient;
    logic        div_exception, div_finish;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_quotient;
    logic [4:0]  wb_tag;
    logic        wb_exception, busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    div_issue_unit dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_signed    (req_signed),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_tag       (req_tag),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_exception (div_exception),
        .div_finish    (div_finish),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_quotient   (wb_quotient),
        .wb_tag        (wb_tag),
        .wb_exception  (wb_exception),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        req_valid = 1'b1; req_signed = s; req_dividend = a; req_divisor = b; req_tag = t;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0; req_valid = 0; req_signed = 0; req_dividend = 0; req_divisor = 0; req_tag = 0;
        div_quotient = 0; div_exception = 0; div_finish = 0; wb_ready = 0;
        #12;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_wb_q", wb_quotient, 0);
        chk("rst_req_ready", req_ready, 1);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);

        // unsigned 100/7, tag 3
        issue(1'b0, 32'd100, 32'd7, 5'd3);
        chk("u_start", div_start, 1);
        chk("u_dvd", div_dividend, 100);
        chk("u_dvs", div_divisor, 7);
        chk("u_busy", busy, 1);
        @(negedge clock);
        chk("u_start_low", div_start, 0);
        chk("u_dvd_hold", div_dividend, 100);
        div_finish = 1; div_quotient = 32'd14;
        @(negedge clock);
        div_finish = 0;
        chk("u_wb_valid", wb_valid, 1);
        chk("u_wb_q", wb_quotient, 14);
        chk("u_wb_tag", wb_tag, 3);
        chk("u_wb_exc", wb_exception, 0);
        wb_ready = 1;
        @(negedge clock);
        wb_ready = 0;
        chk("u_idle_ready", req_ready, 1);
        chk("u_idle_valid", wb_valid, 0);

        // signed -100/7
        issue(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd9);
        chk("s_dvd", div_dividend, 100);
        chk("s_dvs", div_divisor, 7);
        @(negedge clock);
        div_finish = 1; div_quotient = 32'd14;
        @(negedge clock);
        div_finish = 0;
        chk("s_wb_q", wb_quotient, 32'hFFFF_FFF2);
        chk("s_wb_exc", wb_exception, 0);
        chk("s_wb_tag", wb_tag, 9);
        wb_ready = 1; @(negedge clock); wb_ready = 0;

        // divide by zero
        issue(1'b0, 32'd5, 32'd0, 5'd1);
        chk("dz_no_start", div_start, 0);
        chk("dz_wb_valid", wb_valid, 1);
        chk("dz_wb_q", wb_quotient, 0);
        chk("dz_wb_exc", wb_exception, 1);
        wb_ready = 1; @(negedge clock); wb_ready = 0;

        // signed overflow
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
        chk("ov_no_start", div_start, 0);
        chk("ov_wb_valid", wb_valid, 1);
        chk("ov_wb_q", wb_quotient, 32'h8000_0000);
        chk("ov_wb_exc", wb_exception, 1);
        wb_ready = 1; @(negedge clock); wb_ready = 0;

        // timeout: START cycle then 64 WAIT cycles before RESP
        issue(1'b0, 32'd50, 32'd5, 5'd4);
        chk("to_start", div_start, 1);
        n = 0;
        while (!wb_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("to_latency", n, 65);
        chk("to_wb_exc", wb_exception, 1);
        chk("to_wb_q", wb_quotient, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_valid", wb_valid, 1);
            chk("bp_q", wb_quotient, 0);
            chk("bp_tag", wb_tag, 4);
            chk("bp_req_ready", req_ready, 0);
        end
        wb_ready = 1; @(negedge clock); wb_ready = 0;
        chk("bp_idle_ready", req_ready, 1);
        chk("bp_idle_valid", wb_valid, 0);

        // async reset in WAIT
        issue(1'b0, 32'd9, 32'd3, 5'd7);
        @(negedge clock);
        @(negedge clock);
        chk("ra_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("ra_busy_clr", busy, 0);
        chk("ra_dvd_clr", div_dividend, 0);
        chk("ra_dvs_clr", div_divisor, 0);
        chk("ra_tag_clr", wb_tag, 0);
        @(negedge clock); reset = 1'b1;
        div_finish = 1; div_quotient = 32'd3;
        @(negedge clock);
        div_finish = 0;
        chk("ra_stray_valid", wb_valid, 0);
        chk("ra_ready", req_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_unit.md
Name: div_issue_unit

Overview:
- Upstream issue/writeback stage for the divider module: accepts a divide request from execute, handles signs and special cases, drives the divider core's start/operand inputs, and waits for finish.
- Holds the signed result and exception flag for writeback under a valid/ready handshake.
- Its busy output joins the divider's stall to freeze the pipeline.
- The divider core performs unsigned division on magnitudes only.

Parameters:
- WIDTH, 32, operand/quotient width.
- TAG_W, 5, destination register tag width.
- TIMEOUT, 64, max cycles from start to finish before the operation is forced to fail.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute presents a divide request.
- req_ready  out  1  unit can accept a request.
- req_signed  in  1  1 = signed divide, 0 = unsigned.
- req_dividend  in  WIDTH  dividend.
- req_divisor  in  WIDTH  divisor.
- req_tag  in  TAG_W  destination register.
- div_start  out  1  one-cycle start pulse to the divider core.
- div_dividend  out  WIDTH  unsigned dividend magnitude to the core.
- div_divisor  out  WIDTH  unsigned divisor magnitude to the core.
- div_quotient  in  WIDTH  core quotient; valid when div_finish=1.
- div_exception  in  1  core exception; sampled with div_finish.
- div_finish  in  1  core completion.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts the result.
- wb_quotient  out  WIDTH  final signed or unsigned quotient.
- wb_tag  out  TAG_W  destination tag.
- wb_exception  out  1  divide-by-zero, signed overflow, core exception, or timeout.
- busy  out  1  operation in flight (state != IDLE).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, div_start=0, wb_valid=0, busy=0.
  - div_dividend, div_divisor, wb_quotient, wb_tag, wb_exception and the timeout counter all clear to 0.
  - Reset mid-operation abandons the operation; later div_finish pulses are ignored while IDLE.
- FSM states: IDLE, START, WAIT, RESP.
- req_ready = (state==IDLE). Accept occurs when req_valid and req_ready are both 1.
- On accept in IDLE:
  - Latch tag, signed flag, and neg_q = req_signed & (dividend[MSB] ^ divisor[MSB]).
  - Latch magnitudes: two's complement of a negative signed operand, raw value otherwise. The magnitude of 0x80000000 is 0x80000000.
  - If divisor==0: go to RESP with quotient 0, exception 1; the core is not started.
  - Else if signed and dividend==0x80000000 and divisor==0xFFFFFFFF: go to RESP with quotient 0x80000000, exception 1; the core is not started.
  - Else: go to START.
- START (exactly 1 cycle): div_start=1, operands stable; clear the timeout counter; go to WAIT.
- WAIT:
  - div_start=0; div_dividend/div_divisor held stable; counter increments each cycle.
  - On div_finish=1: capture quotient (negated if neg_q), capture exception=div_exception, go to RESP.
  - If the counter reaches TIMEOUT-1 without finish: go to RESP with quotient 0, exception 1.
  - If finish and timeout coincide, finish wins.
- RESP:
  - wb_valid=1; wb_quotient, wb_tag and wb_exception stay stable until wb_ready=1.
  - On wb_ready=1, go to IDLE the next cycle.
  - req_ready stays 0 in RESP, so there is no same-cycle back-to-back accept. Minimum spacing between accepts is 3 cycles for the special-case paths and 4 + core latency otherwise.
- div_finish outside WAIT is ignored.
- Result latency:
  - Normal path: wb_valid rises 1 cycle after the div_finish cycle.
  - Special-case paths: wb_valid rises 1 cycle after accept.
- All outputs are registered except req_ready and busy, which are decoded from the state.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE, START, WAIT, RESP);
  - constants WIDTH, TAG_W, TIMEOUT;
  - constants INT_MIN=0x80000000 and ALL_ONES=0xFFFFFFFF.
- One natural sub-module, div_sign_fix: combinational magnitude conversion and conditional negation. It is instantiated twice for operands and once for the quotient.
- The FSM, counter and output registers live in div_issue_unit.

Test Plan:
- Unsigned divide: dividend 100, divisor 7, unsigned, tag 3.
  - div_start pulses once with operands 100/7.
  - Core returns finish with 14 → wb_valid with quotient 14, tag 3, exception 0.
- Signed divide: dividend -100 (0xFFFFFF9C), divisor 7.
  - Core receives 100/7; core returns 14 → wb_quotient 0xFFFFFFF2, exception 0.
- Divide by zero: dividend 5, divisor 0.
  - div_start never asserts.
  - wb_valid 1 cycle after accept with quotient 0, exception 1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF, signed.
  - No div_start.
  - wb_quotient 0x80000000, exception 1.
- Timeout and backpressure: div_finish withheld for 64 cycles.
  - wb_valid asserts with exception 1.
  - Hold wb_ready=0 for 5 cycles: outputs stable, req_ready=0; then wb_ready=1 → IDLE, req_ready=1.
- Reset mid-operation: reset=0 during WAIT.
  - All outputs clear immediately (asynchronously).
  - A subsequent stray div_finish produces no wb_valid.
